// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, default widths and the NOP bubble encoding.
package proc_pkg;

    localparam int INSTR_W_DEF = 16;
    localparam int ADDR_W_DEF  = 8;

    localparam logic [3:0] OPC_NOP = 4'b1000;
    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_MUL = 4'b0010;
    localparam logic [3:0] OPC_XOR = 4'b0100;
    localparam logic [3:0] OPC_INC = 4'b0011;
    localparam logic [3:0] OPC_CMP = 4'b0110;
    localparam logic [3:0] OPC_BEQ = 4'b1011;
    localparam logic [3:0] OPC_JMP = 4'b1111;
    localparam logic [3:0] OPC_LD  = 4'b1101;
    localparam logic [3:0] OPC_ST  = 4'b1010;
    localparam logic [3:0] OPC_RES = 4'b1100;

    // Bubble instruction at the default width; decodes to an all-zero control word.
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = {{(INSTR_W_DEF-4){1'b0}}, OPC_NOP};

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, load captures, otherwise hold.
module if_id_reg
    import proc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_d,
    input  logic               valid_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [ADDR_W-1:0]  pc_q,
    output logic               valid_q
);

    localparam logic [INSTR_W-1:0] NOP_W = {{(INSTR_W-4){1'b0}}, OPC_NOP};

    // Flush has priority over load; neither means the stage is stalled and holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_W;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP_W;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, imem request and IF/ID register with stall/redirect.
module fetch_stage
    import proc_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int          PC_INC   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic               id_valid
);

    localparam logic [INSTR_W-1:0] NOP_W = {{(INSTR_W-4){1'b0}}, OPC_NOP};
    localparam logic [ADDR_W-1:0]  INC_W = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0]  next_pc_q, next_pc_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               fv_q, fv_d;
    logic [INSTR_W-1:0] ld_instr;
    logic [ADDR_W-1:0]  ld_pc;

    // Redirect targets go straight to imem so the target is fetched in the redirect cycle.
    assign imem_addr = redirect ? redirect_pc : next_pc_q;
    assign imem_en   = rst_n & (redirect | ~stall);

    // Data arriving while fv_q is low is not a real fetch, so it enters IF/ID as a bubble.
    assign ld_instr = fv_q ? imem_rdata : NOP_W;
    assign ld_pc    = fv_q ? pc_q : '0;

    // Next-state for the fetch pointers: redirect > stall > sequential.
    always_comb begin
        next_pc_d = next_pc_q;
        pc_d      = pc_q;
        fv_d      = fv_q;
        if (redirect) begin
            pc_d      = redirect_pc;
            next_pc_d = redirect_pc + INC_W;
            fv_d      = 1'b1;
        end else if (!stall) begin
            pc_d      = next_pc_q;
            next_pc_d = next_pc_q + INC_W;
            fv_d      = 1'b1;
        end
    end

    // Fetch pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_pc_q <= RESET_PC;
            pc_q      <= RESET_PC;
            fv_q      <= 1'b0;
        end else begin
            next_pc_q <= next_pc_d;
            pc_q      <= pc_d;
            fv_q      <= fv_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect),
        .load    (~stall),
        .instr_d (ld_instr),
        .pc_d    (ld_pc),
        .valid_d (fv_q),
        .instr_q (id_instr),
        .pc_q    (id_pc),
        .valid_q (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle-latency imem model holding imem[i]=0x1000+i.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        id_valid;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_valid    (id_valid)
    );

    // Synchronous imem: read data appears the cycle after an enabled request, held otherwise.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 16'h1000 + {8'h00, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        imem_rdata  = 16'h0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        tick();
        tick();
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_instr", {16'b0, id_instr}, 32'h0008);
        chk("rst_en",    {31'b0, imem_en},  32'h0);

        // Reset release: first address issued, bubble at ID.
        rst_n = 1'b1;
        #1;
        chk("c1_addr",  {24'b0, imem_addr}, 32'h00);
        chk("c1_en",    {31'b0, imem_en},   32'h1);
        chk("c1_valid", {31'b0, id_valid},  32'h0);
        tick();
        chk("c2_addr",  {24'b0, imem_addr}, 32'h01);
        chk("c2_valid", {31'b0, id_valid},  32'h0);
        tick();
        chk("c3_instr", {16'b0, id_instr},  32'h1000);
        chk("c3_pc",    {24'b0, id_pc},     32'h00);
        chk("c3_valid", {31'b0, id_valid},  32'h1);
        chk("c3_addr",  {24'b0, imem_addr}, 32'h02);

        // Sequential run up to id_pc=0x05, then stall 3 cycles.
        for (int i = 0; i < 5; i++) tick();
        chk("pre_stall_pc", {24'b0, id_pc}, 32'h05);
        stall = 1'b1;
        #1;
        chk("stall_en", {31'b0, imem_en}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    {24'b0, id_pc},    32'h05);
            chk("stall_instr", {16'b0, id_instr}, 32'h1005);
        end
        stall = 1'b0;
        tick();
        chk("rel_pc6",    {24'b0, id_pc},    32'h06);
        chk("rel_instr6", {16'b0, id_instr}, 32'h1006);
        tick();
        chk("rel_pc7",    {24'b0, id_pc},    32'h07);
        chk("rel_instr7", {16'b0, id_instr}, 32'h1007);

        // Redirect to 0x40 while id_pc=0x10.
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rd_pc", {24'b0, id_pc}, 32'h10);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        #1;
        chk("rd_addr", {24'b0, imem_addr}, 32'h40);
        tick();
        redirect = 1'b0;
        chk("rd_bub_valid", {31'b0, id_valid},  32'h0);
        chk("rd_bub_instr", {16'b0, id_instr},  32'h0008);
        tick();
        chk("rd_tgt_pc",    {24'b0, id_pc},     32'h40);
        chk("rd_tgt_instr", {16'b0, id_instr},  32'h1040);
        chk("rd_tgt_valid", {31'b0, id_valid},  32'h1);

        // Redirect and stall together: redirect wins.
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 8'h20;
        #1;
        chk("rs_en",   {31'b0, imem_en},   32'h1);
        chk("rs_addr", {24'b0, imem_addr}, 32'h20);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        chk("rs_pc",    {24'b0, id_pc},    32'h20);
        chk("rs_instr", {16'b0, id_instr}, 32'h1020);

        // Back-to-back redirects: the last target wins.
        redirect    = 1'b1;
        redirect_pc = 8'h50;
        tick();
        redirect_pc = 8'h60;
        tick();
        redirect = 1'b0;
        chk("rr_bub_valid", {31'b0, id_valid}, 32'h0);
        tick();
        chk("rr_pc",    {24'b0, id_pc},    32'h60);
        chk("rr_instr", {16'b0, id_instr}, 32'h1060);

        // Sequential wrap from 0xFE.
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        tick();
        chk("wr_pc_fe", {24'b0, id_pc}, 32'hFE);
        tick();
        chk("wr_pc_ff", {24'b0, id_pc}, 32'hFF);
        chk("wr_v_ff",  {31'b0, id_valid}, 32'h1);
        tick();
        chk("wr_pc_00",    {24'b0, id_pc},    32'h00);
        chk("wr_instr_00", {16'b0, id_instr}, 32'h1000);
        chk("wr_v_00",     {31'b0, id_valid}, 32'h1);

        // Async reset in the middle of a stall with id_pc=0x33.
        redirect    = 1'b1;
        redirect_pc = 8'h33;
        tick();
        redirect = 1'b0;
        tick();
        chk("ms_pc", {24'b0, id_pc}, 32'h33);
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ms_rst_valid", {31'b0, id_valid}, 32'h0);
        chk("ms_rst_instr", {16'b0, id_instr}, 32'h0008);
        chk("ms_rst_pc",    {24'b0, id_pc},    32'h00);
        tick();

        // Release with stall held: bubble persists and nothing is issued.
        rst_n = 1'b1;
        tick();
        tick();
        chk("rs_stall_valid", {31'b0, id_valid},  32'h0);
        chk("rs_stall_en",    {31'b0, imem_en},   32'h0);
        chk("rs_stall_addr",  {24'b0, imem_addr}, 32'h00);
        stall = 1'b0;
        #1;
        chk("restart_en", {31'b0, imem_en}, 32'h1);
        tick();
        chk("restart_bub", {31'b0, id_valid}, 32'h0);
        tick();
        chk("restart_pc",    {24'b0, id_pc},    32'h00);
        chk("restart_instr", {16'b0, id_instr}, 32'h1000);
        chk("restart_valid", {31'b0, id_valid}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
